// File: rtl/sobel_line_delay_ctrl_if.sv
// Purpose : bus between the Sobel line-delay controller and its 2048x8
//           synchronous line FIFO.
// Signals : fifo_rst   - FIFO reset (controller -> FIFO)
//           fifo_we    - write enable, fifo_di write data
//           fifo_re    - read enable; fifo_do is valid the cycle after
//           fifo_empty / fifo_full / fifo_afull - FIFO status flags
// Modports: master = controller side, slave = FIFO side.
interface sobel_line_delay_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              fifo_rst;
  logic              fifo_we;
  logic [DATA_W-1:0] fifo_di;
  logic              fifo_re;
  logic [DATA_W-1:0] fifo_do;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_afull;

  modport master (
    output fifo_rst, fifo_we, fifo_di, fifo_re,
    input  fifo_do, fifo_empty, fifo_full, fifo_afull
  );

  modport slave (
    input  fifo_rst, fifo_we, fifo_di, fifo_re,
    output fifo_do, fifo_empty, fifo_full, fifo_afull
  );
endinterface

// File: rtl/sobel_line_delay_ctrl.sv
// Purpose : write/read controller for the line FIFO in the Sobel line-buffer
//           path. Fills the FIFO with one full line, then pops one pixel per
//           incoming pixel so the FIFO output is the same column of the
//           previous line. Emits the column-aligned pixel pair and keeps
//           sticky overflow/underflow/fill error flags.
// Ports   : clk, rst (sync, active high)
//           frame_start, pix_valid, pix_data - incoming pixel stream
//           fifo (master)                    - line FIFO bus
//           out_valid, out_cur, out_prev, out_col - aligned pixel pair
//           streaming                        - high in STREAM
//           overflow_err, underflow_err, fill_err - sticky, cleared by rst only
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | after reset, waiting for frame_start; pixels ignored
// FLUSH  | FIFO held in reset for FLUSH_LEN cycles, col cleared
// FILL   | first line of the frame written into the FIFO, no reads
// STREAM | write + read per pixel, aligned pair emitted one cycle later
module sobel_line_delay_ctrl #(
  parameter int DATA_W    = 8,
  parameter int H_ACTIVE  = 1920,
  parameter int COL_W     = 11,
  parameter int FLUSH_LEN = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  pix_valid,
  input  logic [DATA_W-1:0]     pix_data,
  sobel_line_delay_ctrl_if.master fifo,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_cur,
  output logic [DATA_W-1:0]     out_prev,
  output logic [COL_W-1:0]      out_col,
  output logic                  streaming,
  output logic                  overflow_err,
  output logic                  underflow_err,
  output logic                  fill_err
);

  localparam int FL_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  typedef enum logic [1:0] {IDLE, FLUSH, FILL, STREAM} state_t;

  state_t           state, state_nxt;
  logic [COL_W-1:0] col;
  logic [FL_W-1:0]  flush_cnt;
  logic             fill_chk;
  logic             prev_ok;
  logic             accept;
  logic             stream_px;
  logic             col_wrap;

  // A pixel arriving together with frame_start is dropped.
  assign accept    = pix_valid && !frame_start && (state == FILL || state == STREAM);
  assign stream_px = accept && (state == STREAM);
  assign col_wrap  = (col == COL_W'(H_ACTIVE - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (frame_start) begin
      state_nxt = FLUSH;
    end else begin
      case (state)
        FLUSH:   if (flush_cnt == '0) state_nxt = FILL;
        FILL:    if (accept && col_wrap) state_nxt = STREAM;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    fifo.fifo_rst = rst || (state == FLUSH);
    fifo.fifo_we  = accept;
    fifo.fifo_di  = pix_data;
    // An empty FIFO is never popped; the pair still goes out with prev = 0.
    fifo.fifo_re  = stream_px && !fifo.fifo_empty;
    streaming     = (state == STREAM);
  end

  // FIFO read data appears one cycle after fifo_re, alongside the registered
  // current pixel, so it is muxed straight through rather than registered.
  assign out_prev = prev_ok ? fifo.fifo_do : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      col           <= '0;
      flush_cnt     <= '0;
      fill_chk      <= 1'b0;
      prev_ok       <= 1'b0;
      out_valid     <= 1'b0;
      out_cur       <= '0;
      out_col       <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
      fill_err      <= 1'b0;
    end else begin
      if (frame_start)
        flush_cnt <= FL_W'(FLUSH_LEN - 1);
      else if (state == FLUSH && flush_cnt != '0)
        flush_cnt <= flush_cnt - FL_W'(1);

      if (state == FLUSH)
        col <= '0;
      else if (accept)
        col <= col_wrap ? '0 : col + COL_W'(1);

      // Almost-full is judged one cycle after the last FILL write so the
      // FIFO flag has had its update edge.
      fill_chk <= (state == FILL) && accept && col_wrap;
      if (fill_chk && !fifo.fifo_afull) fill_err <= 1'b1;

      if (accept && fifo.fifo_full)      overflow_err  <= 1'b1;
      if (stream_px && fifo.fifo_empty)  underflow_err <= 1'b1;

      out_valid <= stream_px;
      prev_ok   <= stream_px && !fifo.fifo_empty;
      if (stream_px) begin
        out_cur <= pix_data;
        out_col <= col;
      end
    end
  end

endmodule

// File: tb/tb_sobel_line_delay_ctrl.sv
// Purpose : directed bench for sobel_line_delay_ctrl with H_ACTIVE = 8 and a
//           small behavioural line FIFO (almost-full at 8 entries).
module tb_sobel_line_delay_ctrl;
  localparam int DW = 8;
  localparam int HA = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          out_valid;
  logic [DW-1:0] out_cur;
  logic [DW-1:0] out_prev;
  logic [CW-1:0] out_col;
  logic          streaming;
  logic          overflow_err;
  logic          underflow_err;
  logic          fill_err;

  int errors = 0;
  int checks = 0;
  int we_tot = 0;
  int re_tot = 0;

  logic force_full = 1'b0;
  logic force_empty = 1'b0;
  logic force_afull_low = 1'b0;

  sobel_line_delay_ctrl_if #(.DATA_W(DW)) bus ();

  sobel_line_delay_ctrl #(
    .DATA_W(DW), .H_ACTIVE(HA), .COL_W(CW), .FLUSH_LEN(2)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_data(pix_data), .fifo(bus), .out_valid(out_valid), .out_cur(out_cur),
    .out_prev(out_prev), .out_col(out_col), .streaming(streaming),
    .overflow_err(overflow_err), .underflow_err(underflow_err), .fill_err(fill_err)
  );

  always #5 clk = ~clk;

  // Behavioural 16-deep synchronous FIFO, registered read data.
  logic [DW-1:0] mem [16];
  logic [3:0]    wp = '0;
  logic [3:0]    rp = '0;
  logic [4:0]    cnt = '0;
  logic [DW-1:0] fdo = '0;
  logic          we_ok, re_ok;

  assign we_ok          = bus.fifo_we && !bus.fifo_full;
  assign re_ok          = bus.fifo_re && (cnt != 5'd0);
  assign bus.fifo_do    = fdo;
  assign bus.fifo_empty = force_empty || (cnt == 5'd0);
  assign bus.fifo_full  = force_full || (cnt == 5'd16);
  assign bus.fifo_afull = !force_afull_low && (cnt >= 5'd8);

  always @(posedge clk) begin
    if (bus.fifo_rst) begin
      wp <= '0; rp <= '0; cnt <= '0; fdo <= '0;
    end else begin
      if (we_ok) begin mem[wp] <= bus.fifo_di; wp <= wp + 4'd1; end
      if (re_ok) begin fdo <= mem[rp]; rp <= rp + 4'd1; end
      cnt <= cnt + 5'(we_ok) - 5'(re_ok);
    end
  end

  always @(negedge clk) begin
    if (bus.fifo_we) we_tot <= we_tot + 1;
    if (bus.fifo_re) re_tot <= re_tot + 1;
  end

  task automatic drive(input logic pv, input logic [DW-1:0] pd, input logic fs);
    pix_valid = pv; pix_data = pd; frame_start = fs;
    @(posedge clk); #1;
  endtask

  task automatic count_flush(output int n);
    n = 0;
    while (bus.fifo_rst && n < 10) begin n++; drive(1'b0, '0, 1'b0); end
  endtask

  task automatic test_reset();
    int w0;
    rst = 1'b1;
    drive(1'b0, '0, 1'b0); drive(1'b0, '0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (streaming !== 1'b0) begin errors++; $display("FAIL rst_streaming got=%b exp=0", streaming); end
    checks++; if ({out_cur, out_prev, out_col} !== '0) begin errors++; $display("FAIL rst_outputs got=%h/%h/%0d exp=0", out_cur, out_prev, out_col); end
    checks++; if ({overflow_err, underflow_err, fill_err} !== 3'b000) begin errors++; $display("FAIL rst_errs got=%b exp=000", {overflow_err, underflow_err, fill_err}); end
    checks++; if ({bus.fifo_we, bus.fifo_re, bus.fifo_rst} !== 3'b001) begin errors++; $display("FAIL rst_fifo_ctl got=%b exp=001", {bus.fifo_we, bus.fifo_re, bus.fifo_rst}); end
    rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    checks++; if (bus.fifo_rst !== 1'b0) begin errors++; $display("FAIL idle_fifo_rst got=%b exp=0", bus.fifo_rst); end
    w0 = we_tot;
    drive(1'b1, 8'hAA, 1'b0); drive(1'b0, '0, 1'b0);
    checks++; if (we_tot - w0 !== 0) begin errors++; $display("FAIL idle_ignore_we got=%0d exp=0", we_tot - w0); end
  endtask

  task automatic test_fill();
    int n, w0, r0;
    drive(1'b0, '0, 1'b1);
    count_flush(n);
    checks++; if (n !== 2) begin errors++; $display("FAIL fill_flush_len got=%0d exp=2", n); end
    w0 = we_tot; r0 = re_tot;
    for (int i = 0; i < HA; i++) begin
      drive(1'b1, 8'(8'h10 + i), 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_out_valid[%0d] got=%b exp=0", i, out_valid); end
    end
    checks++; if (streaming !== 1'b1) begin errors++; $display("FAIL fill_to_stream got=%b exp=1", streaming); end
    checks++; if (we_tot - w0 !== HA) begin errors++; $display("FAIL fill_we_count got=%0d exp=%0d", we_tot - w0, HA); end
    checks++; if (re_tot - r0 !== 0) begin errors++; $display("FAIL fill_re_count got=%0d exp=0", re_tot - r0); end
    drive(1'b0, '0, 1'b0); drive(1'b0, '0, 1'b0);
    checks++; if (fill_err !== 1'b0) begin errors++; $display("FAIL fill_err_clean got=%b exp=0", fill_err); end
  endtask

  task automatic test_stream();
    int w0, r0;
    w0 = we_tot; r0 = re_tot;
    for (int i = 0; i < HA; i++) begin
      drive(1'b1, 8'(8'h20 + i), 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_cur !== 8'(8'h20 + i) || out_prev !== 8'(8'h10 + i) || out_col !== CW'(i)) begin
        errors++;
        $display("FAIL stream_pair[%0d] got v=%b cur=%h prev=%h col=%0d exp v=1 cur=%h prev=%h col=%0d",
                 i, out_valid, out_cur, out_prev, out_col, 8'(8'h20 + i), 8'(8'h10 + i), i);
      end
    end
    drive(1'b0, '0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_idle_valid got=%b exp=0", out_valid); end
    checks++; if (we_tot - w0 !== HA || re_tot - r0 !== HA) begin errors++; $display("FAIL stream_we_re got=%0d/%0d exp=%0d/%0d", we_tot - w0, re_tot - r0, HA, HA); end
  endtask

  task automatic test_gaps();
    int w0, r0;
    w0 = we_tot; r0 = re_tot;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h30 + i), 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_cur !== 8'(8'h30 + i) || out_prev !== 8'(8'h20 + i) || out_col !== CW'(i)) begin
        errors++;
        $display("FAIL gap_pair[%0d] got v=%b cur=%h prev=%h col=%0d exp v=1 cur=%h prev=%h col=%0d",
                 i, out_valid, out_cur, out_prev, out_col, 8'(8'h30 + i), 8'(8'h20 + i), i);
      end
      drive(1'b0, '0, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || out_col !== CW'(i) || streaming !== 1'b1) begin
        errors++;
        $display("FAIL gap_hold[%0d] got v=%b col=%0d strm=%b exp v=0 col=%0d strm=1", i, out_valid, out_col, streaming, i);
      end
      drive(1'b0, '0, 1'b0);
    end
    checks++; if (we_tot - w0 !== 4 || re_tot - r0 !== 4) begin errors++; $display("FAIL gap_we_re got=%0d/%0d exp=4/4", we_tot - w0, re_tot - r0); end
  endtask

  task automatic test_frame_restart();
    int n, w0, r0;
    w0 = we_tot;
    drive(1'b1, 8'h34, 1'b1);
    checks++; if (we_tot - w0 !== 0) begin errors++; $display("FAIL restart_drop_we got=%0d exp=0", we_tot - w0); end
    checks++; if (out_valid !== 1'b0 || bus.fifo_rst !== 1'b1) begin errors++; $display("FAIL restart_flush got v=%b frst=%b exp v=0 frst=1", out_valid, bus.fifo_rst); end
    count_flush(n);
    checks++; if (n !== 2) begin errors++; $display("FAIL restart_flush_len got=%0d exp=2", n); end
    w0 = we_tot; r0 = re_tot;
    for (int i = 0; i < HA; i++) begin
      drive(1'b1, 8'(8'h40 + i), 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL refill_out_valid[%0d] got=%b exp=0", i, out_valid); end
    end
    checks++; if (streaming !== 1'b1 || we_tot - w0 !== HA || re_tot - r0 !== 0) begin
      errors++; $display("FAIL refill_end got strm=%b we=%0d re=%0d exp strm=1 we=%0d re=0", streaming, we_tot - w0, re_tot - r0, HA);
    end
    drive(1'b0, '0, 1'b0); drive(1'b0, '0, 1'b0);
    checks++; if (fill_err !== 1'b0) begin errors++; $display("FAIL refill_fill_err got=%b exp=0", fill_err); end
  endtask

  task automatic test_underflow();
    int n, r0;
    force_empty = 1'b1;
    r0 = re_tot;
    drive(1'b1, 8'h55, 1'b0);
    force_empty = 1'b0;
    checks++; if (re_tot - r0 !== 0) begin errors++; $display("FAIL under_re got=%0d exp=0", re_tot - r0); end
    checks++; if (underflow_err !== 1'b1 || overflow_err !== 1'b0) begin errors++; $display("FAIL under_flags got u=%b o=%b exp u=1 o=0", underflow_err, overflow_err); end
    checks++;
    if (out_valid !== 1'b1 || out_cur !== 8'h55 || out_prev !== 8'h00 || out_col !== CW'(0)) begin
      errors++; $display("FAIL under_pair got v=%b cur=%h prev=%h col=%0d exp v=1 cur=55 prev=00 col=0", out_valid, out_cur, out_prev, out_col);
    end
    drive(1'b0, '0, 1'b1);
    count_flush(n);
    checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL under_sticky got=%b exp=1", underflow_err); end
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL under_rst_clear got=%b exp=0", underflow_err); end
    rst = 1'b0;
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic test_overflow_fill();
    int n;
    drive(1'b0, '0, 1'b1);
    count_flush(n);
    force_full = 1'b1;
    drive(1'b1, 8'h60, 1'b0);
    force_full = 1'b0;
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL over_flag got=%b exp=1", overflow_err); end
    force_afull_low = 1'b1;
    for (int i = 1; i < HA; i++) drive(1'b1, 8'(8'h60 + i), 1'b0);
    checks++; if (streaming !== 1'b1 || fill_err !== 1'b0) begin errors++; $display("FAIL fill_err_early got strm=%b ferr=%b exp strm=1 ferr=0", streaming, fill_err); end
    drive(1'b0, '0, 1'b0);
    force_afull_low = 1'b0;
    checks++; if (fill_err !== 1'b1) begin errors++; $display("FAIL fill_err_set got=%b exp=1", fill_err); end
    drive(1'b0, '0, 1'b1);
    checks++; if (overflow_err !== 1'b1 || fill_err !== 1'b1) begin errors++; $display("FAIL errs_sticky got o=%b f=%b exp 1/1", overflow_err, fill_err); end
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_data = '0;
    test_reset();
    test_fill();
    test_stream();
    test_gaps();
    test_frame_restart();
    test_underflow();
    test_overflow_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sobel_line_delay_ctrl.md
Name: sobel_line_delay_ctrl

Overview:
- Write/read controller for the 2048x8 synchronous line FIFO (almost-full at 1920) in the Sobel line-buffer path.
- Pushes each incoming active pixel into the FIFO.
- Once one full line is stored, pops one pixel per incoming pixel, so the FIFO output is the same column from the previous line.
- Emits current and previous-line pixels column-aligned to the Sobel window stage, and monitors FIFO flags for overflow and underflow.

Parameters:
DATA_W, 8, pixel width; equals the FIFO data width
H_ACTIVE, 1920, active pixels per line; 2..2047
COL_W, 11, column counter width; ceil(log2(H_ACTIVE))
FLUSH_LEN, 2, cycles fifo_rst is held at frame start

Ports:
clk  in  1  system clock; FIFO runs on the same clock
rst  in  1  synchronous active-high reset
frame_start  in  1  one-cycle pulse before first pixel of a frame
pix_valid  in  1  incoming pixel strobe
pix_data  in  DATA_W  incoming pixel
fifo_rst  out  1  to FIFO rst; high while rst=1 or in FLUSH
fifo_we  out  1  FIFO write enable
fifo_di  out  DATA_W  FIFO write data
fifo_re  out  1  FIFO read enable
fifo_do  in  DATA_W  FIFO read data; valid the cycle after fifo_re
fifo_empty  in  1  FIFO empty flag
fifo_full  in  1  FIFO full flag
fifo_afull  in  1  FIFO almost-full flag
out_valid  out  1  aligned pixel pair valid
out_cur  out  DATA_W  current-line pixel
out_prev  out  DATA_W  previous-line pixel, same column
out_col  out  COL_W  column of the pair
streaming  out  1  high in STREAM state
overflow_err  out  1  sticky; write attempted while fifo_full
underflow_err  out  1  sticky; read needed while fifo_empty
fill_err  out  1  sticky; fifo_afull low at FILL->STREAM

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; col=0.
  - out_valid, out_cur, out_prev, out_col, streaming = 0; all sticky errors = 0.
  - fifo_we=fifo_re=0; fifo_rst=1 combinationally while rst=1.
- States and transitions:
  - IDLE: wait for frame_start; pix_valid is ignored.
  - FLUSH: fifo_rst=1 for FLUSH_LEN cycles, col=0; pix_valid ignored; then -> FILL.
  - FILL: on each pix_valid, fifo_we=1 and fifo_di=pix_data in the same cycle (combinational from pix_valid); no reads; out_valid=0.
    - col increments per pixel and wraps at H_ACTIVE-1 -> 0.
    - On the wrap pixel -> STREAM; fill_err is set if fifo_afull=0 in the following cycle.
  - STREAM: on each pix_valid, fifo_we=1 and fifo_re=1 in the same cycle.
    - Next cycle: out_valid=1, out_prev=fifo_do, out_cur=registered pix_data, out_col=registered col.
    - Latency pix_valid -> out_valid is exactly 1 cycle; back-to-back pixels give back-to-back outputs.
    - col wraps per line; stays in STREAM until the next frame_start or rst.
- frame_start in any state:
  - -> FLUSH next cycle; a pix_valid in the same cycle is dropped.
  - out_valid is forced 0 from the next cycle.
  - Sticky errors are NOT cleared; only rst clears them.
- Boundaries:
  - fifo_full with a pending write: write still issued (FIFO ignores it); overflow_err=1.
  - fifo_empty in STREAM with pix_valid: fifo_re suppressed; underflow_err=1; output still produced with out_prev=0.
  - Simultaneous read and write at full or empty follows the two rules above; no other arbitration.
  - Gaps in pix_valid (blanking) hold col and state; no FIFO access.
- rst mid-line: state and counters return to reset values; FIFO contents discarded through fifo_rst.
- Widths: col is modulo H_ACTIVE, never equal to H_ACTIVE; no arithmetic on pixel data.

Test Plan:
- H_ACTIVE=8; rst, frame_start, 8 pixels 0x10..0x17 -> exactly 8 fifo_we, 0 fifo_re, out_valid=0; streaming=1 after the 8th pixel; fill_err=0 (FIFO model afull threshold set to 8).
- Continue with line 2 pixels 0x20..0x27 -> 8 outputs, 1-cycle latency; pairs (cur,prev)=(0x20,0x10)..(0x27,0x17); out_col=0..7.
- Line 3 with 2-cycle gaps between pixels -> same pairing (0x3n,0x2n); col and state hold during gaps; no extra fifo_we or fifo_re.
- frame_start mid-line 3 at col=4 -> fifo_rst high 2 cycles, out_valid=0; next line 0x40..0x47 produces no output (re-FILL).
- Force fifo_empty=1 in STREAM with one pixel -> fifo_re=0, underflow_err=1, stays 1 across the next frame_start; rst clears it.
- Force fifo_full=1 during FILL -> overflow_err=1; hold fifo_afull=0 at FILL end -> fill_err=1.
